// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display-path signal bundle between ALU top level and seven-segment decoder
interface seven_seg_scan_ctrl_if;
    logic       disp_en;
    logic       load;
    logic [7:0] y_in;
    logic [3:0] op_in;
    logic [3:0] an;
    logic [7:0] y_disp;
    logic [3:0] op_disp;
    logic       pending;
    logic       overrun;
    logic       frame_tick;

    modport master (
        output disp_en, load, y_in, op_in,
        input  an, y_disp, op_disp, pending, overrun, frame_tick
    );

    modport slave (
        input  disp_en, load, y_in, op_in,
        output an, y_disp, op_disp, pending, overrun, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit scan controller with frame-synchronised result commit
// Optional macro SEG_SCAN_BLANK_EN: blank slot 1 always and slot 3 when the high nibble is zero.
module seven_seg_scan_ctrl #(
    parameter int CLK_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        SLOT_OP = 2'd0,
        SLOT_1  = 2'd1,
        SLOT_LO = 2'd2,
        SLOT_HI = 2'd3
    } slot_e;

    logic [CW-1:0] cnt_q, cnt_d;
    slot_e         slot_q, slot_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    y_disp_q, y_disp_d;
    logic [3:0]    op_disp_q, op_disp_d;
    logic [7:0]    pend_y_q, pend_y_d;
    logic [3:0]    pend_op_q, pend_op_d;
    logic          pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          frame_tick_q, frame_tick_d;
    logic          cnt_wrap;
    logic          boundary;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            slot_q       <= SLOT_OP;
            an_q         <= 4'b1111;
            y_disp_q     <= 8'h00;
            op_disp_q    <= 4'h0;
            pend_y_q     <= 8'h00;
            pend_op_q    <= 4'h0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            an_q         <= an_d;
            y_disp_q     <= y_disp_d;
            op_disp_q    <= op_disp_d;
            pend_y_q     <= pend_y_d;
            pend_op_q    <= pend_op_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        cnt_wrap     = (cnt_q == CNT_MAX);
        cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
        slot_d       = cnt_wrap ? slot_e'(slot_q + 2'd1) : slot_q;
        boundary     = cnt_wrap && (slot_q == SLOT_HI);
        frame_tick_d = boundary;

        y_disp_d     = y_disp_q;
        op_disp_d    = op_disp_q;
        pend_y_d     = pend_y_q;
        pend_op_d    = pend_op_q;
        pending_d    = pending_q;
        overrun_d    = 1'b0;

        // A load landing on the boundary edge goes straight to the display registers.
        if (bus.load) begin
            if (boundary) begin
                y_disp_d  = bus.y_in;
                op_disp_d = bus.op_in;
                pending_d = 1'b0;
            end else begin
                pend_y_d  = bus.y_in;
                pend_op_d = bus.op_in;
                pending_d = 1'b1;
                overrun_d = pending_q;
            end
        end else if (boundary && pending_q) begin
            y_disp_d  = pend_y_q;
            op_disp_d = pend_op_q;
            pending_d = 1'b0;
        end

        // Anode pattern is registered against the slot being entered.
        unique case (slot_d)
            SLOT_OP: an_d = 4'b1110;
            SLOT_1:  an_d = 4'b1101;
            SLOT_LO: an_d = 4'b1011;
            SLOT_HI: an_d = 4'b0111;
            default: an_d = 4'b1111;
        endcase
`ifdef SEG_SCAN_BLANK_EN
        if (slot_d == SLOT_1) begin
            an_d = 4'b1111;
        end
        if ((slot_d == SLOT_HI) && (y_disp_d[7:4] == 4'h0)) begin
            an_d = 4'b1111;
        end
`else
`endif
        if (!bus.disp_en) begin
            an_d = 4'b1111;
        end
    end

    assign bus.an         = an_q;
    assign bus.y_disp     = y_disp_q;
    assign bus.op_disp    = op_disp_q;
    assign bus.pending    = pending_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard bench for seven_seg_scan_ctrl with CLK_DIV=4
module tb_seven_seg_scan_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   failed;
    int   ft_org;

    seven_seg_scan_ctrl_if bus ();

    seven_seg_scan_ctrl #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [18:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] an_for(int s, logic [7:0] y);
        logic [3:0] a;
        case (s)
            0:       a = 4'b1110;
            1:       a = 4'b1101;
            2:       a = 4'b1011;
            default: a = 4'b0111;
        endcase
`ifdef SEG_SCAN_BLANK_EN
        if (s == 1) a = 4'b1111;
        if (s == 3 && y[7:4] == 4'h0) a = 4'b1111;
`else
        if (y === 8'hxx) a = 4'bxxxx;
`endif
        return a;
    endfunction

    // Slot index shown at cycle c, given the cycle of a known frame boundary.
    function automatic int slot_of(int c, int org);
        if (c >= org) return ((c - org) / 4) % 4;
        return 3 - (((org - 1 - c) / 4) % 4);
    endfunction

    task automatic expect_at(int c, string nm, logic [3:0] an, logic ft,
                             logic [7:0] y, logic [3:0] op, logic pend, logic ovr);
        exp_t e;
        e.cyc  = c;
        e.val  = {an, ft, y, op, pend, ovr};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic at_cyc(int c);
        while (cyc != c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(int c, logic [7:0] y, logic [3:0] op);
        at_cyc(c);
        bus.load  = 1'b1;
        bus.y_in  = y;
        bus.op_in = op;
        at_cyc(c + 1);
        bus.load  = 1'b0;
    endtask

    logic [18:0] act;
    exp_t        cur;

    always @(negedge clk) begin
        act = {bus.an, bus.frame_tick, bus.y_disp, bus.op_disp, bus.pending, bus.overrun};
        if (bus.frame_tick) begin
            tests = tests + 1;
            if (cyc < ft_org || ((cyc - ft_org) % 16) != 0) begin
                failed = failed + 1;
                $display("FAIL frame_tick_schedule cyc=%0d got=1 want=0", cyc);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur   = sb.pop_front();
            tests = tests + 1;
            if (cur.cyc != cyc) begin
                failed = failed + 1;
                $display("FAIL %s missed check for cyc=%0d at cyc=%0d", cur.name, cur.cyc, cyc);
            end else if (act !== cur.val) begin
                failed = failed + 1;
                $display("FAIL %s cyc=%0d got{an,ft,y,op,pend,ovr}=%05h want=%05h",
                         cur.name, cyc, act, cur.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tests       = 0;
        failed      = 0;
        ft_org      = 19;
        rst_n       = 1'b0;
        bus.disp_en = 1'b1;
        bus.load    = 1'b0;
        bus.y_in    = 8'h00;
        bus.op_in   = 4'h0;

        expect_at(2, "reset_state", 4'hF, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        expect_at(3, "reset_state", 4'hF, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        for (int c = 4; c <= 20; c++)
            expect_at(c, "first_frame_scan", an_for(slot_of(c, 19), 8'h00), c == 19,
                      8'h00, 4'h0, 1'b0, 1'b0);

        expect_at(23, "load_pending",   an_for(slot_of(23, 19), 8'h00), 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        expect_at(34, "hold_pre_frame", an_for(3, 8'h00),               1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        expect_at(35, "commit_a5",      4'b1110,                        1'b1, 8'hA5, 4'h3, 1'b0, 1'b0);
        expect_at(36, "after_commit",   4'b1110,                        1'b0, 8'hA5, 4'h3, 1'b0, 1'b0);

        expect_at(39, "first_load",     an_for(slot_of(39, 19), 8'hA5), 1'b0, 8'hA5, 4'h3, 1'b1, 1'b0);
        expect_at(43, "overrun_pulse",  an_for(slot_of(43, 19), 8'hA5), 1'b0, 8'hA5, 4'h3, 1'b1, 1'b1);
        expect_at(44, "overrun_end",    an_for(slot_of(44, 19), 8'hA5), 1'b0, 8'hA5, 4'h3, 1'b1, 1'b0);
        expect_at(51, "commit_last",    4'b1110,                        1'b1, 8'h34, 4'h2, 1'b0, 1'b0);

        expect_at(66, "pre_bypass",     an_for(3, 8'h34),               1'b0, 8'h34, 4'h2, 1'b0, 1'b0);
        expect_at(67, "bypass_commit",  4'b1110,                        1'b1, 8'h7F, 4'h9, 1'b0, 1'b0);
        expect_at(68, "bypass_after",   4'b1110,                        1'b0, 8'h7F, 4'h9, 1'b0, 1'b0);

        expect_at(77, "pre_disable",    an_for(slot_of(77, 19), 8'h7F), 1'b0, 8'h7F, 4'h9, 1'b0, 1'b0);
        for (int c = 78; c <= 87; c++)
            expect_at(c, "disabled_blank", 4'hF, c == 83, 8'h7F, 4'h9, 1'b0, 1'b0);
        expect_at(88, "resume_slot",    an_for(slot_of(88, 19), 8'h7F), 1'b0, 8'h7F, 4'h9, 1'b0, 1'b0);

        expect_at(93, "pend_before_rst", an_for(slot_of(93, 19), 8'h7F), 1'b0, 8'h7F, 4'h9, 1'b1, 1'b0);
        expect_at(96, "mid_reset",      4'hF, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        expect_at(97, "mid_reset",      4'hF, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        expect_at(98, "reset_exit",     4'b1110, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        expect_at(113, "discarded",     4'b1110, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
        expect_at(116, "load_05",       an_for(slot_of(116, 113), 8'h00), 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        expect_at(129, "commit_05",     4'b1110, 1'b1, 8'h05, 4'h1, 1'b0, 1'b0);
        expect_at(134, "slot1_y05",     an_for(1, 8'h05), 1'b0, 8'h05, 4'h1, 1'b0, 1'b0);
        expect_at(142, "slot3_y05",     an_for(3, 8'h05), 1'b0, 8'h05, 4'h1, 1'b0, 1'b0);

        at_cyc(3);
        rst_n = 1'b1;
        do_load(22, 8'hA5, 4'h3);
        do_load(38, 8'h12, 4'h1);
        do_load(42, 8'h34, 4'h2);
        do_load(66, 8'h7F, 4'h9);
        at_cyc(77);
        bus.disp_en = 1'b0;
        at_cyc(87);
        bus.disp_en = 1'b1;
        do_load(92, 8'h55, 4'h4);
        at_cyc(95);
        rst_n  = 1'b0;
        ft_org = 113;
        at_cyc(97);
        rst_n = 1'b1;
        do_load(115, 8'h05, 4'h1);
        at_cyc(150);

        while (sb.size() > 0) begin
            cur    = sb.pop_front();
            tests  = tests + 1;
            failed = failed + 1;
            $display("FAIL %s never checked (cyc=%0d)", cur.name, cur.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
